// File: rtl/handshake_fifo_buffer.sv
// rtl/handshake_fifo_buffer.sv - elastic valid/ready FIFO buffer, NUM_SLOTS deep, in-order delivery.
// Optional HANDSHAKE_FIFO_BYPASS_EN: zero-latency pass-through while the buffer is empty.
module handshake_fifo_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int PTR_W = $clog2(NUM_SLOTS);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(NUM_SLOTS);

  logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [PTR_W:0]        count;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic store;
  logic drop;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // ins_ready never looks at outs_ready, so the ready chain is cut here.
  assign ins_ready = ~full & ~rst;
  assign push      = ins_valid & ins_ready;

`ifdef HANDSHAKE_FIFO_BYPASS_EN
  logic bypass;

  assign outs_valid = (~empty | ins_valid) & ~rst;
  assign outs       = empty ? ins : mem[head];
  assign pop        = outs_valid & outs_ready;
  assign bypass     = empty & ins_valid & outs_ready;
  assign store      = push & ~bypass;
  assign drop       = pop & ~empty;
`else
  assign outs_valid = ~empty & ~rst;
  assign outs       = mem[head];
  assign pop        = outs_valid & outs_ready;
  assign store      = push;
  assign drop       = pop;
`endif

  // Storage is deliberately not reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[tail] <= ins;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (store) begin
        tail <= tail + 1'b1;
      end
      if (drop) begin
        head <= head + 1'b1;
      end
      case ({store, drop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// tb/tb_handshake_fifo_buffer.sv - randomized and directed bench for handshake_fifo_buffer.
module tb_handshake_fifo_buffer;

  localparam int DW = 32;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] ins;
  logic          ins_valid;
  logic          ins_ready;
  logic [DW-1:0] outs;
  logic          outs_valid;
  logic          outs_ready;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] delivered[$];

  handshake_fifo_buffer #(.DATA_WIDTH(DW), .NUM_SLOTS(NS)) dut (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs       (outs),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check outputs, then advance the model at the rising edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic rs);
    int  sz;
    logic exp_valid;
    logic [DW-1:0] exp_data;
    logic bypass;
    ins_valid  = v;
    ins        = d;
    outs_ready = r;
    rst        = rs;
    #1;
    sz = model_q.size();
    bypass = 1'b0;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
    exp_valid = !rs && (sz != 0 || v);
    exp_data  = (sz == 0) ? d : model_q[0];
    bypass    = !rs && sz == 0 && v && r;
`else
    exp_valid = !rs && sz != 0;
    exp_data  = (sz != 0) ? model_q[0] : '0;
`endif
    check_val("outs_valid", DW'(outs_valid), DW'(exp_valid));
    check_val("ins_ready", DW'(ins_ready), DW'(!rs && sz < NS));
    if (exp_valid) check_val("outs", outs, exp_data);
    if (!rs) check_val("count", DW'(dut.count), DW'(sz));
    @(posedge clk);
    if (rs) begin
      model_q.delete();
    end else if (bypass) begin
      delivered.push_back(d);
    end else begin
      if (sz != 0 && r) delivered.push_back(model_q.pop_front());
      if (v && sz < NS) model_q.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    ins = '0; ins_valid = 1'b0; outs_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Fill then drain
    step(1, 32'h11, 0, 0);
    step(1, 32'h22, 0, 0);
    step(1, 32'h33, 0, 0);
    step(1, 32'h44, 0, 0);
    step(1, 32'h99, 0, 0);
    delivered.delete();
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
    check_val("drain_cnt", DW'(delivered.size()), DW'(4));
    if (delivered.size() == 4) begin
      check_val("drain0", delivered[0], 32'h11);
      check_val("drain3", delivered[3], 32'h44);
    end

    // Full buffer with simultaneous push request and pop
    step(1, 32'h11, 0, 0);
    step(1, 32'h22, 0, 0);
    step(1, 32'h33, 0, 0);
    step(1, 32'h44, 0, 0);
    step(1, 32'h55, 1, 0);
    check_val("full_no_push", DW'(dut.count), DW'(3));
    step(1, 32'h55, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0);

    // Wrap-around stream with toggling outs_ready
    delivered.delete();
    for (int i = 0, k = 0; k < 16 && i < 200; i++) begin
      if (model_q.size() < NS) begin
        step(1, DW'(k), i[0] == 1'b0, 0);
        k++;
      end else begin
        step(0, 0, i[0] == 1'b0, 0);
      end
    end
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    check_val("wrap_cnt", DW'(delivered.size()), DW'(16));
    for (int k = 0; k < 16 && k < delivered.size(); k++) check_val("wrap_order", delivered[k], DW'(k));

    // Reset mid-operation
    step(1, 32'h1, 0, 0);
    step(1, 32'h2, 0, 0);
    step(1, 32'h3, 0, 0);
    step(0, 0, 0, 1);
    check_val("rst_count", DW'(dut.count), DW'(0));
    delivered.delete();
    step(1, 32'hAA, 0, 0);
    step(0, 0, 1, 0);
    check_val("after_rst_first", delivered.size() > 0 ? delivered[0] : '1, 32'hAA);

    // Latency on an empty buffer
    step(1, 32'h7E, 1, 0);
    step(0, 0, 1, 0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 2) != 0), ($urandom_range(0, 59) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
